// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_blitter
// Desc     : Fetches one sprite over an Avalon burst-read master and writes
//            its opaque, on-screen pixels into a 480x360 frame buffer.
// Revision : 1.0
// ============================================================================
module sprite_blitter #(
    parameter int unsigned H_RES       = 480,
    parameter int unsigned V_RES       = 360,
    parameter logic [7:0]  TRANSPARENT = 8'hE3,
    parameter int unsigned FB_AW       = 18
) (
    input  logic             Clk,
    input  logic             Reset,

    input  logic             draw_sprite,
    input  logic [31:0]      sprite_address,
    input  logic [15:0]      sprite_x,
    input  logic [15:0]      sprite_y,
    input  logic [15:0]      sprite_width,
    input  logic [15:0]      sprite_height,
    output logic             done_draw,

    output logic [31:0]      avalon_control_read_base,
    output logic [31:0]      avalon_control_read_length,
    output logic             avalon_control_go,
    input  logic             avalon_control_done,
    output logic             avalon_user_read_buffer,
    input  logic [7:0]       avalon_user_buffer_output_data,
    input  logic             avalon_user_data_available,

    output logic [FB_AW-1:0] fb_addr,
    output logic [7:0]       fb_data_in,
    output logic             fb_write
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_STREAM    = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_draw_d;
    logic [15:0]        r_x;
    logic [15:0]        r_y;
    logic [15:0]        r_w;
    logic [15:0]        r_h;
    logic [15:0]        r_row;
    logic [15:0]        r_col;
    logic               r_done;
    logic               r_go;
    logic [31:0]        r_read_base;
    logic [31:0]        r_read_length;
    logic               r_fb_write;
    logic [FB_AW-1:0]   r_fb_addr;
    logic [7:0]         r_fb_data;

    logic               w_accept;
    logic               w_nonempty;
    logic               w_pop;
    logic               w_col_last;
    logic               w_row_last;
    logic [16:0]        w_sx;
    logic [16:0]        w_sy;
    logic               w_visible;
    logic [FB_AW-1:0]   w_lin_addr;

    assign w_nonempty = (sprite_width != 16'd0) && (sprite_height != 16'd0);
    assign w_col_last = (r_col == r_w - 16'd1);
    assign w_row_last = (r_row == r_h - 16'd1);

    // 17-bit sums so that coordinates near 65535 cannot wrap back on screen
    assign w_sx       = {1'b0, r_x} + {1'b0, r_col};
    assign w_sy       = {1'b0, r_y} + {1'b0, r_row};
    assign w_visible  = (w_sx < 17'(H_RES)) && (w_sy < 17'(V_RES)) &&
                        (avalon_user_buffer_output_data != TRANSPARENT);
    assign w_lin_addr = FB_AW'(w_sy) * FB_AW'(H_RES) + FB_AW'(w_sx);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_pop    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (draw_sprite && !r_draw_d) begin
                    w_accept = 1'b1;
                    w_next   = w_nonempty ? S_LAUNCH : S_FINISH;
                end
            end
            S_LAUNCH: begin
                w_next = S_STREAM;
            end
            S_STREAM: begin
                w_pop = avalon_user_data_available;
                if (w_pop && w_col_last && w_row_last) begin
                    w_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (avalon_control_done) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_draw_d      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_w           <= '0;
            r_h           <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_done        <= 1'b1;
            r_go          <= 1'b0;
            r_read_base   <= '0;
            r_read_length <= '0;
            r_fb_write    <= 1'b0;
            r_fb_addr     <= '0;
            r_fb_data     <= '0;
        end else begin
            r_draw_d   <= draw_sprite;
            r_go       <= 1'b0;
            r_fb_write <= 1'b0;

            if (w_accept) begin
                r_x    <= sprite_x;
                r_y    <= sprite_y;
                r_w    <= sprite_width;
                r_h    <= sprite_height;
                r_row  <= '0;
                r_col  <= '0;
                r_done <= 1'b0;
                // Burst parameters go out together with the go pulse in LAUNCH
                if (w_nonempty) begin
                    r_go          <= 1'b1;
                    r_read_base   <= sprite_address;
                    r_read_length <= {16'd0, sprite_width} * {16'd0, sprite_height};
                end
            end

            if (w_pop) begin
                if (w_visible) begin
                    r_fb_write <= 1'b1;
                    r_fb_addr  <= w_lin_addr;
                    r_fb_data  <= avalon_user_buffer_output_data;
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= r_row + 16'd1;
                end else begin
                    r_col <= r_col + 16'd1;
                end
            end

            if (r_state == S_FINISH) begin
                r_done <= 1'b1;
            end
        end
    end

    assign done_draw                  = r_done;
    assign avalon_control_go          = r_go;
    assign avalon_control_read_base   = r_read_base;
    assign avalon_control_read_length = r_read_length;
    assign avalon_user_read_buffer    = w_pop;
    assign fb_write                   = r_fb_write;
    assign fb_addr                    = r_fb_addr;
    assign fb_data_in                 = r_fb_data;

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_blitter
// Desc     : Scoreboard bench for sprite_blitter with a byte-queue read master.
// Revision : 1.0
// ============================================================================
module tb_sprite_blitter;

    logic        Clk;
    logic        Reset;
    logic        draw_sprite;
    logic [31:0] sprite_address;
    logic [15:0] sprite_x, sprite_y, sprite_width, sprite_height;
    logic        done_draw;
    logic [31:0] avalon_control_read_base;
    logic [31:0] avalon_control_read_length;
    logic        avalon_control_go;
    logic        avalon_control_done;
    logic        avalon_user_read_buffer;
    logic [7:0]  avalon_user_buffer_output_data;
    logic        avalon_user_data_available;
    logic [17:0] fb_addr;
    logic [7:0]  fb_data_in;
    logic        fb_write;

    sprite_blitter dut (
        .Clk                            (Clk),
        .Reset                          (Reset),
        .draw_sprite                    (draw_sprite),
        .sprite_address                 (sprite_address),
        .sprite_x                       (sprite_x),
        .sprite_y                       (sprite_y),
        .sprite_width                   (sprite_width),
        .sprite_height                  (sprite_height),
        .done_draw                      (done_draw),
        .avalon_control_read_base       (avalon_control_read_base),
        .avalon_control_read_length     (avalon_control_read_length),
        .avalon_control_go              (avalon_control_go),
        .avalon_control_done            (avalon_control_done),
        .avalon_user_read_buffer        (avalon_user_read_buffer),
        .avalon_user_buffer_output_data (avalon_user_buffer_output_data),
        .avalon_user_data_available     (avalon_user_data_available),
        .fb_addr                        (fb_addr),
        .fb_data_in                     (fb_data_in),
        .fb_write                       (fb_write)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_pops = 0;

    logic [7:0]  src_q[$];
    logic [17:0] exp_a_q[$];
    logic [7:0]  exp_d_q[$];
    logic [31:0] go_base_q[$];
    logic [31:0] go_len_q[$];

    bit toggle_mode = 1'b0;
    bit phase       = 1'b0;
    bit will_pop    = 1'b0;
    bit popped_last = 1'b0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Read-master model: show-ahead byte queue, pops when read_buffer was high at the edge
    initial begin
        avalon_user_data_available     = 1'b0;
        avalon_user_buffer_output_data = 8'h00;
        avalon_control_done            = 1'b1;
        forever begin
            @(negedge Clk);
            avalon_user_data_available     = (src_q.size() > 0) && (!toggle_mode || phase);
            avalon_user_buffer_output_data = (src_q.size() > 0) ? src_q[0] : 8'h00;
            avalon_control_done            = (src_q.size() == 0);
            #1 will_pop = avalon_user_read_buffer;
            @(posedge Clk);
            #1;
            popped_last = will_pop && Reset;
            if (popped_last) begin
                src_q.delete(0);
                n_pops++;
            end
            phase = !phase;
        end
    end

    // Monitor: compares go pulses and frame-buffer writes against the scoreboard queues
    initial begin
        forever begin
            @(negedge Clk);
            #2;
            if (avalon_control_go) begin
                if (go_base_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_go: got base=0x%0h len=%0d expected no go",
                             avalon_control_read_base, avalon_control_read_length);
                end else begin
                    chk("go_base", avalon_control_read_base, go_base_q[0]);
                    chk("go_length", avalon_control_read_length, go_len_q[0]);
                    go_base_q.delete(0);
                    go_len_q.delete(0);
                end
            end
            if (fb_write) begin
                chk("write_follows_pop", popped_last, 1);
                if (exp_a_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected none",
                             fb_addr, fb_data_in);
                end else begin
                    chk("fb_addr", fb_addr, exp_a_q[0]);
                    chk("fb_data", fb_data_in, exp_d_q[0]);
                    exp_a_q.delete(0);
                    exp_d_q.delete(0);
                end
            end
        end
    end

    task automatic push_wr(input logic [17:0] a, input logic [7:0] d);
        exp_a_q.push_back(a);
        exp_d_q.push_back(d);
    endtask

    task automatic push_go(input logic [31:0] b, input logic [31:0] l);
        go_base_q.push_back(b);
        go_len_q.push_back(l);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done_draw"}, done_draw, 1);
        chk({tag, "_go"}, avalon_control_go, 0);
        chk({tag, "_read_buffer"}, avalon_user_read_buffer, 0);
        chk({tag, "_fb_write"}, fb_write, 0);
        chk({tag, "_fb_addr"}, fb_addr, 0);
        chk({tag, "_fb_data"}, fb_data_in, 0);
        chk({tag, "_read_base"}, avalon_control_read_base, 0);
        chk({tag, "_read_length"}, avalon_control_read_length, 0);
    endtask

    task automatic start_draw(input logic [31:0] a, input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] w, input logic [15:0] h, input int hold);
        @(negedge Clk);
        n_pops         = 0;
        sprite_address = a;
        sprite_x       = x;
        sprite_y       = y;
        sprite_width   = w;
        sprite_height  = h;
        draw_sprite    = 1'b1;
        @(negedge Clk);
        chk("done_low_after_accept", done_draw, 0);
        repeat (hold - 1) @(negedge Clk);
        draw_sprite = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done_draw && k < 500) begin
            @(negedge Clk);
            k++;
        end
        chk(nm, done_draw, 1);
    endtask

    task automatic finish_checks(input string tag, input int exp_pops);
        repeat (3) @(negedge Clk);
        chk({tag, "_pops"}, n_pops, exp_pops);
        chk({tag, "_writes_left"}, exp_a_q.size(), 0);
        chk({tag, "_go_left"}, go_base_q.size(), 0);
    endtask

    initial begin
        Reset          = 1'b0;
        draw_sprite    = 1'b0;
        sprite_address = '0;
        sprite_x       = '0;
        sprite_y       = '0;
        sprite_width   = '0;
        sprite_height  = '0;
        #12;
        chk_reset_outputs("por");
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        // 2x2 at origin
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_go(32'h1000, 32'd4);
        push_wr(18'd0, 8'h01);
        push_wr(18'd1, 8'h02);
        push_wr(18'd480, 8'h03);
        push_wr(18'd481, 8'h04);
        start_draw(32'h1000, 16'd0, 16'd0, 16'd2, 16'd2, 1);
        wait_done("t1_done");
        finish_checks("t1", 4);

        // transparent pixel skipped
        src_q = '{8'h11, 8'hE3, 8'h13};
        push_go(32'h2000, 32'd3);
        push_wr(18'd2410, 8'h11);
        push_wr(18'd2412, 8'h13);
        start_draw(32'h2000, 16'd10, 16'd5, 16'd3, 16'd1, 1);
        wait_done("t2_done");
        finish_checks("t2", 3);

        // right and bottom clipping
        src_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        push_go(32'h3000, 32'd8);
        push_wr(18'd172798, 8'h21);
        push_wr(18'd172799, 8'h22);
        start_draw(32'h3000, 16'd478, 16'd359, 16'd4, 16'd2, 1);
        wait_done("t3_done");
        finish_checks("t3", 8);

        // zero width: no bus activity
        start_draw(32'h3100, 16'd0, 16'd0, 16'd0, 16'd5, 1);
        wait_done("t4_done");
        finish_checks("t4", 0);

        // held request, ignored second edge, throttled data
        toggle_mode = 1'b1;
        src_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        push_go(32'h6000, 32'd8);
        for (int i = 0; i < 4; i++) push_wr(18'(96100 + i), 8'(8'h31 + i));
        for (int i = 0; i < 4; i++) push_wr(18'(96580 + i), 8'(8'h35 + i));
        start_draw(32'h6000, 16'd100, 16'd200, 16'd4, 16'd2, 4);
        begin
            int k = 0;
            while (n_pops < 3 && k < 200) begin
                @(negedge Clk);
                k++;
            end
            chk("t5_reached_3_pops", n_pops >= 3, 1);
        end
        chk("t5_busy_at_second_edge", done_draw, 0);
        draw_sprite = 1'b1;
        repeat (2) @(negedge Clk);
        draw_sprite = 1'b0;
        wait_done("t5_done");
        finish_checks("t5", 8);
        repeat (5) @(negedge Clk);
        chk("t5_no_second_draw", done_draw, 1);
        toggle_mode = 1'b0;

        // reset in the middle of a 4x4 draw, master has only delivered 3 bytes
        src_q = '{8'h40, 8'h41, 8'h42};
        push_go(32'h4000, 32'd16);
        push_wr(18'd0, 8'h40);
        push_wr(18'd1, 8'h41);
        push_wr(18'd2, 8'h42);
        start_draw(32'h4000, 16'd0, 16'd0, 16'd4, 16'd4, 1);
        begin
            int k = 0;
            while ((n_pops < 3 || exp_a_q.size() != 0) && k < 200) begin
                @(negedge Clk);
                k++;
            end
            chk("t6_three_pixels_written", exp_a_q.size(), 0);
        end
        chk("t6_busy_before_reset", done_draw, 0);
        @(posedge Clk);
        #3 Reset = 1'b0;
        #1;
        chk_reset_outputs("mid");
        repeat (2) @(negedge Clk);
        src_q.delete();
        Reset = 1'b1;
        finish_checks("t6", 3);

        // fresh draw after reset
        src_q = '{8'h55};
        push_go(32'h5000, 32'd1);
        push_wr(18'd482, 8'h55);
        start_draw(32'h5000, 16'd2, 16'd1, 16'd1, 16'd1, 1);
        wait_done("t7_done");
        finish_checks("t7", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
